// File: rtl/ring_flasher_param.sv
// Ring flasher: repeated forward/backward sweeps over a parameterised LED ring.
// It fills the ring, then toggles it until the ring reads all-off or the round limit expires.
module ring_flasher_param #(
  parameter int N_LEDS      = 16,
  parameter int FWD_STEPS   = 8,
  parameter int BACK_STEPS  = 4,
  parameter int FILL_CYCLES = 3,
  parameter int TICK_DIV    = 1,
  parameter int MAX_ROUNDS  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mirror,
  output logic [N_LEDS-1:0] led,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int POS_W  = $clog2(N_LEDS);
  localparam int STEP_W = $clog2(FWD_STEPS + 1);
  localparam int CYC_W  = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam int RND_W  = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N_LEDS - 1);
  localparam logic [STEP_W-1:0] STEP_FWD  = STEP_W'(FWD_STEPS);
  localparam logic [STEP_W-1:0] STEP_BACK = STEP_W'(BACK_STEPS);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(FILL_CYCLES - 1);
  localparam logic [RND_W-1:0]  RND_LAST  = RND_W'(MAX_ROUNDS - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FILL_FWD  = 3'd1;
  localparam logic [2:0] S_FILL_BACK = 3'd2;
  localparam logic [2:0] S_TOG_FWD   = 3'd3;
  localparam logic [2:0] S_TOG_BACK  = 3'd4;
  localparam logic [2:0] S_CHECK     = 3'd5;

  logic [2:0]        state;
  logic [POS_W-1:0]  pos;
  logic [STEP_W-1:0] step;
  logic [CYC_W-1:0]  cyc;
  logic [RND_W-1:0]  rounds;
  logic [PRE_W-1:0]  presc;
  logic              dir;

  logic              tick;
  logic              is_tog;
  logic [POS_W-1:0]  idx;
  logic [POS_W-1:0]  pos_inc;
  logic [POS_W-1:0]  pos_dec;

  assign tick    = (presc == PRE_LAST);
  assign is_tog  = (state == S_TOG_FWD) || (state == S_TOG_BACK);
  assign idx     = dir ? (POS_LAST - pos) : pos;
  assign pos_inc = (pos == POS_LAST) ? '0 : pos + 1'b1;
  assign pos_dec = (pos == '0) ? POS_LAST : pos - 1'b1;
  assign busy    = (state != S_IDLE);

  // NOTE: all state below is written with non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (abort || state == S_IDLE || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      led     <= '0;
      pos     <= '0;
      step    <= '0;
      cyc     <= '0;
      rounds  <= '0;
      dir     <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      if (abort) begin
        state  <= S_IDLE;
        led    <= '0;
        pos    <= '0;
        step   <= '0;
        cyc    <= '0;
        rounds <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            led    <= '0;
            pos    <= '0;
            step   <= '0;
            cyc    <= '0;
            rounds <= '0;
            if (start) begin
              dir   <= mirror;
              state <= S_FILL_FWD;
            end
          end
          S_FILL_FWD, S_TOG_FWD: begin
            if (tick) begin
              if (step < STEP_FWD) begin
                led[idx] <= is_tog ? ~led[idx] : 1'b1;
                pos      <= pos_inc;
                step     <= step + 1'b1;
              end else begin
                pos   <= pos_dec;
                step  <= STEP_BACK;
                state <= is_tog ? S_TOG_BACK : S_FILL_BACK;
              end
            end
          end
          S_FILL_BACK, S_TOG_BACK: begin
            if (tick) begin
              if (step != '0) begin
                led[idx] <= is_tog ? ~led[idx] : 1'b0;
                pos      <= pos_dec;
                step     <= step - 1'b1;
              end else begin
                pos  <= pos_inc;
                step <= '0;
                if (is_tog) begin
                  state <= S_CHECK;
                end else if (cyc != CYC_LAST) begin
                  cyc   <= cyc + 1'b1;
                  state <= S_FILL_FWD;
                end else begin
                  cyc   <= '0;
                  state <= S_TOG_FWD;
                end
              end
            end
          end
          S_CHECK: begin
            if (tick) begin
              if (led == '0) begin
                done  <= 1'b1;
                state <= S_IDLE;
              end else if (rounds == RND_LAST) begin
                led     <= '0;
                timeout <= 1'b1;
                state   <= S_IDLE;
              end else begin
                rounds <= rounds + 1'b1;
                step   <= '0;
                state  <= S_TOG_FWD;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ring_flasher_param.md
RING_FLASHER_PARAM -- requirements
Module: ring_flasher_param

Interface
REQ-001 The module SHALL have a parameter N_LEDS, default 16, giving the ring length (range 4..64, any integer, not only powers of two).
REQ-002 The module SHALL have a parameter FWD_STEPS, default 8, giving the number of LEDs stepped per forward sweep.
REQ-003 The module SHALL have a parameter BACK_STEPS, default 4, giving the number of LEDs stepped per backward sweep; the legal range is 1 <= BACK_STEPS < FWD_STEPS <= N_LEDS.
REQ-004 The module SHALL have a parameter FILL_CYCLES, default 3, giving the number of fill cycles before toggle mode (range >= 1).
REQ-005 The module SHALL have a parameter TICK_DIV, default 1, giving the clocks per step tick (range >= 1).
REQ-006 The module SHALL have a parameter MAX_ROUNDS, default 15, giving the maximum number of toggle rounds before timeout.
REQ-007 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-008 The module SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-009 The module SHALL have port start, input, 1 bit: a level that starts a sequence when the block is idle.
REQ-010 The module SHALL have port abort, input, 1 bit: a synchronous stop.
REQ-011 The module SHALL have port mirror, input, 1 bit: the direction select, latched at start.
REQ-012 The module SHALL have port led, output, N_LEDS bits: the LED outputs, active-high, registered.
REQ-013 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The module SHALL have port done, output, 1 bit: a one-clock pulse on normal completion.
REQ-015 The module SHALL have port timeout, output, 1 bit: a one-clock pulse on a MAX_ROUNDS abort.

Function
REQ-016 The block SHALL implement the states IDLE, FILL_FWD, FILL_BACK, TOG_FWD, TOG_BACK and CHECK; any illegal encoding SHALL go to IDLE on the next clock.
REQ-017 Tick generation: the prescaler SHALL be held at 0 in IDLE and SHALL assert tick when it equals TICK_DIV-1, then wrap; when TICK_DIV=1, tick SHALL be high every clock.
REQ-018 Every non-IDLE state SHALL act only on tick; IDLE SHALL act every clock.
REQ-019 IDLE SHALL: set led=0, pos=0, step=0 and cyc=0; if start=1, latch mirror into dir and go to FILL_FWD.
REQ-020 The physical index SHALL be pos when dir=0 and N_LEDS-1-pos when dir=1; pos SHALL be incremented and decremented modulo N_LEDS.
REQ-021 FILL_FWD SHALL, while step<FWD_STEPS: set led[idx]=1, pos+1, step+1; otherwise (transition tick): pos-1, step=BACK_STEPS, go to FILL_BACK.
REQ-022 FILL_BACK SHALL, while step>0: clear led[idx]=0, pos-1, step-1; otherwise (transition tick): pos+1, step=0; if cyc<FILL_CYCLES-1 then cyc+1 and go to FILL_FWD, else cyc=0 and go to TOG_FWD.
REQ-023 TOG_FWD and TOG_BACK SHALL be identical to FILL_FWD and FILL_BACK except that they invert led[idx]; at the end of TOG_BACK the block SHALL go to CHECK.
REQ-024 CHECK (one tick) SHALL: if led==0, go to IDLE and pulse done; else, if rounds==MAX_ROUNDS-1, clear led, go to IDLE and pulse timeout; else rounds+1, step=0, go to TOG_FWD.
REQ-025 abort=1 on any clock SHALL override all other behaviour: on the next edge, state=IDLE, led=0, and neither done nor timeout pulses; abort while in IDLE SHALL have no effect other than blocking start.
REQ-026 start asserted while busy SHALL be ignored; start held high through completion SHALL restart the sequence on the clock after done.
REQ-027 The internal counters SHALL be sized with $clog2 of their maximum value plus 1, with no overflow at the parameter extremes.

Reset
REQ-028 While rst_n=0 the block SHALL asynchronously set led=0, busy=0, done=0, timeout=0, state=IDLE, and clear all counters and dir.
REQ-029 Reset asserted mid-sequence SHALL take effect immediately, without waiting for a tick.
REQ-030 After rst_n rises, the block SHALL remain in IDLE until start is sampled high.

Verification
REQ-031 With defaults, mirror=0, start pulsed: the first fill cycle SHALL end at led=0x000F, then 0x00FF, then 0x0FFF; each cycle SHALL take 14 ticks.
REQ-032 With defaults: the toggle-round ends SHALL be 0xFFFF, 0xFFF0, 0xFF00, 0xF000, 0x0000; done SHALL pulse 117 clocks after the start edge, with busy falling at the same time.
REQ-033 Same as REQ-031 with mirror=1: the fill-cycle ends SHALL be 0xF000, 0xFF00, 0xFFF0 (bit-reversed images).
REQ-034 With TICK_DIV=4, defaults otherwise: every led change SHALL occur exactly 4 clocks apart, and done SHALL pulse at 468 clocks.
REQ-035 With abort pulsed during TOG_FWD: the next clock SHALL show led=0, busy=0, done=0 and timeout=0; with rst_n pulsed low mid-FILL_BACK, outputs SHALL clear without a clock edge.
REQ-036 With N_LEDS=12, FWD_STEPS=7, BACK_STEPS=2 and MAX_ROUNDS=2, where the sequence does not reach 0 within 2 rounds: timeout SHALL pulse at the second CHECK with led=0 next, and pos SHALL wrap correctly across index 11->0.
